// File: rtl/acia_tx_arb.sv
// Round-robin arbiter sharing one ACIA transmitter between NUM_REQ byte streams.
// Owners may lock across a message with `last`; a watchdog breaks abandoned locks.
//
// state    | meaning
// IDLE     | no owner; pick the next valid requester from rr_ptr
// SEND     | single-cycle ACIA write strobe
// WAIT_SET | wait for busy flag to rise (fallback after 4 cycles)
// WAIT_CLR | wait for the character to finish on the line
// HOLD     | locked to owner mid-message; watchdog counts idle cycles
module acia_tx_arb #(
  parameter int NUM_REQ      = 2,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 acia_wr_o,
  output logic                 acia_rs_o,
  output logic [7:0]           acia_din_o,
  input  logic                 acia_txf_i,
  output logic                 lock_timeout_o
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int WW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] WD_LAST = WW'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_SET,
    S_WAIT_CLR,
    S_HOLD
  } state_t;

  state_t             state_q;
  logic [IW-1:0]      rr_ptr_q;
  logic [IW-1:0]      owner_q;
  logic [NUM_REQ-1:0] grant_q;
  logic               wr_q;
  logic               last_q;
  logic               lock_timeout_q;
  logic [7:0]         din_q;
  logic [1:0]         fb_cnt_q;
  logic [WW-1:0]      wdog_q;

  logic [IW-1:0]      winner;
  logic [IW-1:0]      sel_idx;
  logic [IW-1:0]      next_ptr;
  logic [7:0]         sel_data;
  logic               sel_last;
  logic               any_valid;
  logic               owner_valid;
  int                 scan_idx;

  // Scan downward so the requester closest to rr_ptr is the last to overwrite.
  always_comb begin
    winner   = rr_ptr_q;
    scan_idx = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      scan_idx = int'(rr_ptr_q) + i;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (req_valid_i[scan_idx]) winner = IW'(scan_idx);
    end
  end

  always_comb begin
    any_valid   = |req_valid_i;
    owner_valid = req_valid_i[owner_q];
    sel_idx     = (state_q == S_HOLD) ? owner_q : winner;
    sel_data    = req_data_i[{sel_idx, 3'b000} +: 8];
    sel_last    = req_last_i[sel_idx];
    next_ptr    = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    req_ready_o = '0;
    if (state_q == S_IDLE && any_valid) req_ready_o[winner] = 1'b1;
    else if (state_q == S_HOLD)         req_ready_o = grant_q & req_valid_i;
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      rr_ptr_q       <= '0;
      owner_q        <= '0;
      grant_q        <= '0;
      wr_q           <= 1'b0;
      last_q         <= 1'b0;
      lock_timeout_q <= 1'b0;
      din_q          <= 8'h00;
      fb_cnt_q       <= '0;
      wdog_q         <= '0;
    end else begin
      wr_q           <= 1'b0;
      lock_timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (any_valid) begin
            owner_q <= winner;
            grant_q <= NUM_REQ'(1) << winner;
            din_q   <= sel_data;
            last_q  <= sel_last;
            wr_q    <= 1'b1;
            state_q <= S_SEND;
          end
        end
        S_SEND: begin
          fb_cnt_q <= '0;
          state_q  <= S_WAIT_SET;
        end
        S_WAIT_SET: begin
          if (acia_txf_i || fb_cnt_q == 2'd3) state_q <= S_WAIT_CLR;
          else                                fb_cnt_q <= fb_cnt_q + 1'b1;
        end
        S_WAIT_CLR: begin
          if (!acia_txf_i) begin
            if (last_q) begin
              grant_q  <= '0;
              rr_ptr_q <= next_ptr;
              state_q  <= S_IDLE;
            end else begin
              wdog_q  <= '0;
              state_q <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (owner_valid) begin
            din_q   <= sel_data;
            last_q  <= sel_last;
            wr_q    <= 1'b1;
            state_q <= S_SEND;
          end else if (LOCK_TIMEOUT != 0) begin
            // Abandoned lock: release exactly as a completed last byte would.
            if (wdog_q == WD_LAST) begin
              lock_timeout_q <= 1'b1;
              grant_q        <= '0;
              rr_ptr_q       <= next_ptr;
              state_q        <= S_IDLE;
            end else if (wdog_q != '1) begin
              wdog_q <= wdog_q + 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant_o        = grant_q;
  assign acia_wr_o      = wr_q;
  assign acia_rs_o      = wr_q;
  assign acia_din_o     = din_q;
  assign lock_timeout_o = lock_timeout_q;

endmodule
